uart_rx_ctrl: RTL and testbench

- Sequencing controller between the UART receiver and the consumer logic.
- Captures each received word into a small FIFO and presents it on a valid/ready interface.
- Runs the receiver's error-acknowledge handshake (err_ack) and keeps overflow/error status.
- Sits directly downstream of the UART receiver and shares its `WORD_LENGTH from globals.vh.

---
 rtl/uart_ctrl_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 60 ++++++
 rtl/uart_rx_ctrl.sv | 136 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared state type and character timing for the UART receive controller.
// Fallback build defaults stand in when the global UART defines are not supplied.
`ifndef WORD_LENGTH
`define WORD_LENGTH 8
`endif
`ifndef Rx_CLKRATE
`define Rx_CLKRATE 1600
`endif
`ifndef BAUD
`define BAUD 160
`endif

package uart_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ERR_ACK  = 2'd1,
      ST_ERR_WAIT = 2'd2
   } rx_ctrl_state_e;

   localparam int unsigned BIT_CYCLES  = `Rx_CLKRATE / `BAUD;
   localparam int unsigned CHAR_CYCLES = 10 * `Rx_CLKRATE / `BAUD;

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with an occupancy counter; flush overrides push and pop.
module uart_sync_fifo #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WORD_W-1:0]            wdata,
   output logic [WORD_W-1:0]            rdata,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         full,
   output logic                         empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still takes a word when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '{default: '0};
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            level <= level + LVL_W'(1);
         end else if (do_pop && !do_push) begin
            level <= level - LVL_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer: buffers words, runs the err_ack handshake, tracks status.
// Optional idle timeout is built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned WORD_W        = `WORD_LENGTH,
   parameter int unsigned DEPTH         = 4,
   parameter int unsigned ERR_CNT_W     = 8,
   parameter int unsigned TIMEOUT_CHARS = 4
) (
   input  logic                        r_clk,
   input  logic                        r_rst,
   input  logic                        enable,
   input  logic                        flush,
   input  logic [WORD_W-1:0]           rx_pckt,
   input  logic                        rx_valid,
   input  logic                        rx_err,
   output logic                        err_ack,
   output logic [WORD_W-1:0]           out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(DEPTH+1)-1:0]  fifo_level,
   output logic                        ovf_sticky,
   output logic [ERR_CNT_W-1:0]        err_cnt,
   output logic                        rx_timeout
);

   rx_ctrl_state_e state;
   rx_ctrl_state_e state_next;
   logic           push_req;
   logic           pop_eff;
   logic           push_acc;
   logic           fifo_full;
   logic           fifo_empty;
   logic           unused_cfg;

   assign unused_cfg = ^{32'(TIMEOUT_CHARS), 32'(CHAR_CYCLES), 32'(BIT_CYCLES)};

   uart_sync_fifo #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (r_clk),
      .rst_n (r_rst),
      .flush (flush),
      .push  (push_req),
      .pop   (out_ready),
      .wdata (rx_pckt),
      .rdata (out_data),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign pop_eff   = out_ready & ~fifo_empty;
   assign push_acc  = push_req & (~fifo_full | pop_eff);

   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // An error outranks a word arriving in the same cycle; words are only taken in idle.
   always_comb begin
      state_next = state;
      push_req   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_err) begin
               state_next = ST_ERR_ACK;
            end else if (rx_valid && enable) begin
               push_req = 1'b1;
            end
         end
         ST_ERR_ACK:  state_next = ST_ERR_WAIT;
         ST_ERR_WAIT: if (!rx_err) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         err_ack    <= 1'b0;
         err_cnt    <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         err_ack <= (state_next == ST_ERR_ACK);
         if (state == ST_ERR_ACK && err_cnt != '1) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
         if (flush) begin
            ovf_sticky <= 1'b0;
         end else if (push_req && fifo_full && !pop_eff) begin
            ovf_sticky <= 1'b1;
         end
      end
   end

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam int unsigned TO_LIMIT = TIMEOUT_CHARS * CHAR_CYCLES;
   localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

   logic [TO_W-1:0] to_cnt;
   logic            to_hold;

   // Pulse lands TO_LIMIT cycles after the last push, then waits for new traffic.
   always_ff @(posedge r_clk or negedge r_rst) begin
      if (!r_rst) begin
         to_cnt     <= '0;
         to_hold    <= 1'b0;
         rx_timeout <= 1'b0;
      end else begin
         rx_timeout <= 1'b0;
         if (flush || push_acc || pop_eff) begin
            to_cnt  <= '0;
            to_hold <= 1'b0;
         end else if (out_valid && !to_hold) begin
            if (to_cnt == TO_W'(TO_LIMIT - 2)) begin
               rx_timeout <= 1'b1;
               to_hold    <= 1'b1;
            end
            to_cnt <= to_cnt + TO_W'(1);
         end
      end
   end
`else
   logic unused_push_acc;
   assign unused_push_acc = push_acc;
   assign rx_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus a randomized run
// compared against a queue-based behavioural model.
module tb_uart_rx_ctrl;
   import uart_ctrl_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic       r_clk = 1'b0;
   logic       r_rst;
   logic       enable;
   logic       flush;
   logic [7:0] rx_pckt;
   logic       rx_valid;
   logic       rx_err;
   logic       err_ack;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] fifo_level;
   logic       ovf_sticky;
   logic [7:0] err_cnt;
   logic       rx_timeout;

   int errors = 0;
   int checks = 0;

   // Model: FIFO contents, sticky overflow, error count, handshake phase (0 idle, 1 ack, 2 wait)
   logic [7:0] m_q[$];
   logic       m_ovf;
   logic [7:0] m_ecnt;
   int         m_phase;

   always #5 r_clk = ~r_clk;

   uart_rx_ctrl #(
      .WORD_W        (8),
      .DEPTH         (DEPTH),
      .ERR_CNT_W     (8),
      .TIMEOUT_CHARS (4)
   ) dut (
      .r_clk      (r_clk),
      .r_rst      (r_rst),
      .enable     (enable),
      .flush      (flush),
      .rx_pckt    (rx_pckt),
      .rx_valid   (rx_valid),
      .rx_err     (rx_err),
      .err_ack    (err_ack),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .ovf_sticky (ovf_sticky),
      .err_cnt    (err_cnt),
      .rx_timeout (rx_timeout)
   );

   task automatic model_reset();
      m_q.delete();
      m_ovf   = 1'b0;
      m_ecnt  = 8'h00;
      m_phase = 0;
   endtask

   task automatic model_step(input logic v, input logic [7:0] d, input logic e,
                             input logic rdy, input logic fl, input logic en);
      bit take;
      take = (m_phase == 0) && !e && v && en;
      if (fl) begin
         m_q.delete();
         m_ovf = 1'b0;
      end else begin
         if (rdy && m_q.size() > 0) void'(m_q.pop_front());
         if (take) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
         end
      end
      if (m_phase == 1 && m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'h01;
      case (m_phase)
         0:       if (e) m_phase = 1;
         1:       m_phase = 2;
         default: if (!e) m_phase = 0;
      endcase
   endtask

   // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
   task automatic tick(input logic v, input logic [7:0] d, input logic e,
                       input logic rdy, input logic fl, input logic en);
      rx_valid  = v;
      rx_pckt   = d;
      rx_err    = e;
      out_ready = rdy;
      flush     = fl;
      enable    = en;
      model_step(v, d, e, rdy, fl, en);
      @(posedge r_clk);
      #1;
   endtask

   task automatic test_reset();
      r_rst = 1'b0;
      rx_valid = 1'b0; rx_pckt = 8'h00; rx_err = 1'b0;
      out_ready = 1'b0; flush = 1'b0; enable = 1'b1;
      model_reset();
      repeat (2) @(posedge r_clk);
      #1;
      checks++;
      if ({out_valid, err_ack, ovf_sticky, rx_timeout} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=0000", {out_valid, err_ack, ovf_sticky, rx_timeout});
      end
      checks++;
      if ({fifo_level, err_cnt, out_data} !== 19'h0) begin
         errors++;
         $display("FAIL reset_values level=%0d cnt=%0d data=%h exp=0", fifo_level, err_cnt, out_data);
      end
      r_rst = 1'b1;
   endtask

   task automatic test_basic();
      tick(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
         errors++;
         $display("FAIL basic_first valid=%b data=%h exp valid=1 data=a5", out_valid, out_data);
      end
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_drain level=%0d valid=%b exp 0/0", fifo_level, out_valid);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 5; i++) tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (fifo_level !== 3'd4 || ovf_sticky !== 1'b1) begin
         errors++;
         $display("FAIL ovf_fill level=%0d ovf=%b exp 4/1", fifo_level, ovf_sticky);
      end
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (out_data !== 8'(i)) begin
            errors++;
            $display("FAIL ovf_drain got=%h exp=%h", out_data, 8'(i));
         end
         tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      checks++;
      if (fifo_level !== 3'd0 || ovf_sticky !== 1'b1) begin
         errors++;
         $display("FAIL ovf_after level=%0d ovf=%b exp 0/1", fifo_level, ovf_sticky);
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] exp_d [4];
      exp_d = '{8'h12, 8'h13, 8'h14, 8'h66};
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b1);
      checks++;
      if (fifo_level !== 3'd4 || ovf_sticky !== 1'b0) begin
         errors++;
         $display("FAIL fullpop_level level=%0d ovf=%b exp 4/0", fifo_level, ovf_sticky);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_data !== exp_d[i]) begin
            errors++;
            $display("FAIL fullpop_order got=%h exp=%h", out_data, exp_d[i]);
         end
         tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
      end
   endtask

   task automatic test_error();
      int acks;
      acks = 0;
      tick(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
      if (err_ack === 1'b1) acks++;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
         if (err_ack === 1'b1) acks++;
      end
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      if (err_ack === 1'b1) acks++;
      checks++;
      if (acks != 1 || err_cnt !== 8'd1 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL err_first acks=%0d cnt=%0d level=%0d exp 1/1/0", acks, err_cnt, fifo_level);
      end
      tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (err_cnt !== 8'd2 || fifo_level !== 3'd0) begin
         errors++;
         $display("FAIL err_second cnt=%0d level=%0d exp 2/0", err_cnt, fifo_level);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) tick(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (fifo_level !== 3'd0 || ovf_sticky !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush level=%0d ovf=%b valid=%b exp 0/0/0", fifo_level, ovf_sticky, out_valid);
      end
      checks++;
      if (err_cnt !== m_ecnt) begin
         errors++;
         $display("FAIL flush_errcnt got=%0d exp=%0d", err_cnt, m_ecnt);
      end
   endtask

   task automatic test_reset_mid_error();
      tick(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (err_ack !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_ack got=%b exp=1", err_ack);
      end
      #2 r_rst = 1'b0;
      #1;
      checks++;
      if (err_ack !== 1'b0 || err_cnt !== 8'd0 || fifo_level !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_async ack=%b cnt=%0d level=%0d valid=%b exp 0", err_ack, err_cnt, fifo_level, out_valid);
      end
      model_reset();
      r_rst = 1'b1;
      tick(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (err_ack !== 1'b0 || fifo_level !== 3'd1 || out_data !== 8'h5A) begin
         errors++;
         $display("FAIL rst_idle ack=%b level=%0d data=%h exp 0/1/5a", err_ack, fifo_level, out_data);
      end
      tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_timeout();
      int pulses;
      int first_at;
      pulses   = 0;
      first_at = -1;
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b1, 8'h9C, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef UART_RX_CTRL_TIMEOUT_EN
      for (int j = 1; j <= int'(4 * CHAR_CYCLES) + 20; j++) begin
         if (rx_timeout === 1'b1) begin
            pulses++;
            if (first_at < 0) first_at = j;
         end
         tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      checks++;
      if (pulses != 1 || first_at != int'(4 * CHAR_CYCLES)) begin
         errors++;
         $display("FAIL timeout_pulse count=%0d at=%0d exp 1 at %0d", pulses, first_at, 4 * CHAR_CYCLES);
      end
`else
      for (int j = 1; j <= 60; j++) begin
         if (rx_timeout !== 1'b0) pulses++;
         tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL timeout_off count=%0d exp=0", pulses);
      end
`endif
      tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_random();
      int   hold;
      logic v, e, rdy, fl, en;
      hold = 0;
      for (int c = 0; c < 600; c++) begin
         if (hold == 0 && $urandom_range(0, 24) == 0) hold = int'($urandom_range(1, 5));
         e = (hold > 0);
         if (hold > 0) hold--;
         v   = ($urandom_range(0, 2) != 0);
         rdy = ($urandom_range(0, 4) < 2);
         fl  = ($urandom_range(0, 59) == 0);
         en  = ($urandom_range(0, 7) != 0);
         tick(v, 8'($urandom), e, rdy, fl, en);
         checks++;
         if (out_valid !== (m_q.size() > 0) || fifo_level !== 3'(m_q.size())) begin
            errors++;
            $display("FAIL rand_level cyc=%0d valid=%b level=%0d exp level=%0d", c, out_valid, fifo_level, m_q.size());
         end
         checks++;
         if (ovf_sticky !== m_ovf || err_cnt !== m_ecnt || err_ack !== (m_phase == 1)) begin
            errors++;
            $display("FAIL rand_status cyc=%0d ovf=%b cnt=%0d ack=%b exp ovf=%b cnt=%0d ack=%b",
                     c, ovf_sticky, err_cnt, err_ack, m_ovf, m_ecnt, (m_phase == 1));
         end
         if (m_q.size() > 0) begin
            checks++;
            if (out_data !== m_q[0]) begin
               errors++;
               $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, out_data, m_q[0]);
            end
         end
`ifndef UART_RX_CTRL_TIMEOUT_EN
         checks++;
         if (rx_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rand_timeout cyc=%0d got=%b exp=0", c, rx_timeout);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_pop();
      test_error();
      test_flush();
      test_reset_mid_error();
      test_timeout();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
